regbank_wb_ctrl: RTL and testbench

Write-back controller for the register bank. It shares the bank's single write port between up to four write-back requesters (ALU, load unit, …) through round-robin arbitration with valid/ready handshakes. It also keeps a busy scoreboard of destination registers so issue logic can stall on read-after-write hazards. It sits between the execution units and the bank's write port, and its busy outputs feed the decode/issue stall logic.

---
 rtl/regbank_wb_ctrl_if.sv | 36 +++
 rtl/regbank_wb_ctrl.sv | 106 ++++++++++
 tb/tb_regbank_wb_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/regbank_wb_ctrl_if.sv
// Write-back port bundle: requester handshakes, scoreboard reserve/check ports
// and the register bank write port.
interface regbank_wb_ctrl_if #(
  parameter int NUMREGS   = 32,
  parameter int DATAWIDTH = 32,
  parameter int NUMREQ    = 2
);
  localparam int AW = $clog2(NUMREGS);

  logic [NUMREQ-1:0]           req_valid_i;
  logic [NUMREQ-1:0]           req_ready_o;
  logic [NUMREQ*AW-1:0]        req_addr_i;
  logic [NUMREQ*DATAWIDTH-1:0] req_data_i;
  logic                        rsv_i;
  logic [AW-1:0]               rsv_addr_i;
  logic                        rsv_conflict_o;
  logic [AW-1:0]               chk_a_addr_i;
  logic [AW-1:0]               chk_b_addr_i;
  logic                        busy_a_o;
  logic                        busy_b_o;
  logic                        we_o;
  logic [AW-1:0]               waddr_o;
  logic [DATAWIDTH-1:0]        wdata_o;

  modport master (
    output req_valid_i, req_addr_i, req_data_i, rsv_i, rsv_addr_i,
           chk_a_addr_i, chk_b_addr_i,
    input  req_ready_o, rsv_conflict_o, busy_a_o, busy_b_o, we_o, waddr_o, wdata_o
  );

  modport slave (
    input  req_valid_i, req_addr_i, req_data_i, rsv_i, rsv_addr_i,
           chk_a_addr_i, chk_b_addr_i,
    output req_ready_o, rsv_conflict_o, busy_a_o, busy_b_o, we_o, waddr_o, wdata_o
  );
endinterface

// File: rtl/regbank_wb_ctrl.sv
// Write-back controller: round-robin arbitration of write-back requesters onto the
// single bank write port, plus a busy scoreboard for read-after-write stalls.
module regbank_wb_ctrl #(
  parameter int NUMREGS      = 32,
  parameter int DATAWIDTH    = 32,
  parameter int NUMREQ       = 2,
  parameter bit R0_HARDWIRED = 1'b1
) (
  input logic              clk_i,
  input logic              rst_ni,
  regbank_wb_ctrl_if.slave bus
);
  localparam int AW = $clog2(NUMREGS);
  localparam int PW = (NUMREQ > 1) ? $clog2(NUMREQ) : 1;

  logic [PW-1:0]        ptr_q, ptr_d;
  logic [NUMREGS-1:0]   busy_q, busy_d;
  logic [NUMREQ-1:0]    grant;
  logic                 acc;
  logic [AW-1:0]        acc_addr;
  logic [DATAWIDTH-1:0] acc_data;
  logic                 acc_drop;
  logic                 rsv_en;
  logic                 conflict_d;
  logic                 we_q, conflict_q;
  logic [AW-1:0]        waddr_q;
  logic [DATAWIDTH-1:0] wdata_q;

  // First pass searches ptr..NUMREQ-1; if empty, the second pass takes the
  // lowest valid index, which is the wrap-around continuation.
  always_comb begin
    grant    = '0;
    acc      = 1'b0;
    acc_addr = '0;
    acc_data = '0;
    ptr_d    = ptr_q;
    for (int k = 0; k < NUMREQ; k++) begin
      if (!acc && bus.req_valid_i[k] && (PW'(k) >= ptr_q)) begin
        acc      = 1'b1;
        grant[k] = 1'b1;
        acc_addr = bus.req_addr_i[k*AW +: AW];
        acc_data = bus.req_data_i[k*DATAWIDTH +: DATAWIDTH];
        ptr_d    = PW'((k + 1) % NUMREQ);
      end
    end
    for (int k = 0; k < NUMREQ; k++) begin
      if (!acc && bus.req_valid_i[k]) begin
        acc      = 1'b1;
        grant[k] = 1'b1;
        acc_addr = bus.req_addr_i[k*AW +: AW];
        acc_data = bus.req_data_i[k*DATAWIDTH +: DATAWIDTH];
        ptr_d    = PW'((k + 1) % NUMREQ);
      end
    end
    if (!rst_ni) begin
      grant = '0;
      acc   = 1'b0;
    end
  end

  assign acc_drop = R0_HARDWIRED && (acc_addr == '0);
  assign rsv_en   = bus.rsv_i && !(R0_HARDWIRED && (bus.rsv_addr_i == '0));

  // A reservation on the same edge as the completing write is a new producer,
  // so set wins over clear and no conflict is flagged.
  always_comb begin
    busy_d = busy_q;
    if (acc)
      busy_d[acc_addr] = 1'b0;
    if (rsv_en)
      busy_d[bus.rsv_addr_i] = 1'b1;
    if (R0_HARDWIRED)
      busy_d[0] = 1'b0;
  end

  assign conflict_d = rsv_en && busy_q[bus.rsv_addr_i] &&
                      !(acc && (acc_addr == bus.rsv_addr_i));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q      <= '0;
      busy_q     <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      conflict_q <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
      we_q       <= acc && !acc_drop;
      if (acc) begin
        waddr_q <= acc_addr;
        wdata_q <= acc_data;
      end
    end
  end

  assign bus.req_ready_o    = grant;
  assign bus.we_o           = we_q;
  assign bus.waddr_o        = waddr_q;
  assign bus.wdata_o        = wdata_q;
  assign bus.rsv_conflict_o = conflict_q;
  assign bus.busy_a_o       = rst_ni && busy_q[bus.chk_a_addr_i];
  assign bus.busy_b_o       = rst_ni && busy_q[bus.chk_b_addr_i];
endmodule

// File: tb/tb_regbank_wb_ctrl.sv
// Bench for regbank_wb_ctrl: directed scenarios then randomized traffic, all
// checked against a cycle-level arbitration/scoreboard model.
module tb_regbank_wb_ctrl;
  localparam int NR   = 2;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  regbank_wb_ctrl_if #(.NUMREGS(NREG), .DATAWIDTH(DW), .NUMREQ(NR)) bus ();

  regbank_wb_ctrl #(
    .NUMREGS(NREG), .DATAWIDTH(DW), .NUMREQ(NR), .R0_HARDWIRED(1'b1)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int          m_ptr;
  bit          m_busy[NREG];
  bit          m_we;
  int          m_waddr;
  logic [DW-1:0] m_wdata;
  bit          m_conf;
  int          last_g;

  bit            v[NR];
  int            a[NR];
  logic [DW-1:0] d[NR];
  bit            rsv;
  int            rsv_a, ca, cb;

  logic [NR-1:0] last_ready;
  logic          last_we, last_busy_a, last_conf;
  logic [AW-1:0] last_waddr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
    m_we = 1'b0; m_waddr = 0; m_wdata = '0; m_conf = 1'b0; last_g = -1;
  endtask

  function automatic int model_grant();
    for (int i = 0; i < NR; i++) begin
      int k;
      k = (m_ptr + i) % NR;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  task automatic apply();
    for (int k = 0; k < NR; k++) begin
      bus.req_valid_i[k]          = v[k];
      bus.req_addr_i[k*AW +: AW]  = AW'(a[k]);
      bus.req_data_i[k*DW +: DW]  = d[k];
    end
    bus.rsv_i        = rsv;
    bus.rsv_addr_i   = AW'(rsv_a);
    bus.chk_a_addr_i = AW'(ca);
    bus.chk_b_addr_i = AW'(cb);
  endtask

  // Drive current inputs, check at the falling edge, advance the model on the rising edge.
  task automatic cycle();
    int g;
    logic [NR-1:0] exp_ready;
    bit old_busy;
    apply();
    @(negedge clk_i);
    g = model_grant();
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check("ready", bus.req_ready_o, exp_ready);
    check("busy_a", bus.busy_a_o, m_busy[ca]);
    check("busy_b", bus.busy_b_o, m_busy[cb]);
    check("we", bus.we_o, m_we);
    check("waddr", bus.waddr_o, m_waddr);
    check("wdata", bus.wdata_o, m_wdata);
    check("conflict", bus.rsv_conflict_o, m_conf);
    last_ready  = bus.req_ready_o;
    last_we     = bus.we_o;
    last_waddr  = bus.waddr_o;
    last_busy_a = bus.busy_a_o;
    last_conf   = bus.rsv_conflict_o;
    @(posedge clk_i);
    old_busy = m_busy[rsv_a];
    if (g >= 0) begin
      m_ptr   = (g + 1) % NR;
      m_we    = (a[g] != 0);
      m_waddr = a[g];
      m_wdata = d[g];
      m_busy[a[g]] = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    m_conf = rsv && (rsv_a != 0) && old_busy && !(g >= 0 && a[g] == rsv_a);
    if (rsv && rsv_a != 0) m_busy[rsv_a] = 1'b1;
    last_g = g;
    #1;
  endtask

  initial begin
    for (int k = 0; k < NR; k++) begin v[k] = 1'b0; a[k] = 0; d[k] = '0; end
    rsv = 1'b0; rsv_a = 0; ca = 0; cb = 0;
    apply();
    model_reset();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_we", bus.we_o, 1'b0);
    check("rst_waddr", bus.waddr_o, '0);
    check("rst_wdata", bus.wdata_o, '0);
    check("rst_conflict", bus.rsv_conflict_o, 1'b0);
    rst_ni = 1'b1;

    // Fairness: both requesters continuously valid
    v[0] = 1; v[1] = 1; a[0] = 5; a[1] = 6; d[0] = 32'hA; d[1] = 32'hB; ca = 5; cb = 6;
    for (int c = 0; c < 4; c++) begin
      cycle();
      check("fair_ready", last_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
      if (c > 0) check("fair_waddr", last_waddr, (c % 2 == 0) ? 6 : 5);
    end

    // Register 0 write is consumed silently
    v[0] = 0; v[1] = 1; a[1] = 0; d[1] = 32'hFFFF_FFFF; ca = 0;
    cycle();
    check("r0_ready", last_ready, 2'b10);
    v[1] = 0;
    cycle();
    check("r0_we", last_we, 1'b0);
    check("r0_busy", last_busy_a, 1'b0);

    // Scoreboard set then clear
    rsv = 1; rsv_a = 7; ca = 7;
    cycle();
    rsv = 0; v[0] = 1; a[0] = 7; d[0] = 32'h1234;
    cycle();
    check("sb_busy_set", last_busy_a, 1'b1);
    v[0] = 0;
    cycle();
    check("sb_busy_clr", last_busy_a, 1'b0);
    check("sb_we", last_we, 1'b1);
    check("sb_waddr", last_waddr, 7);

    // Reservation coinciding with the completing write
    rsv = 1; rsv_a = 9; ca = 9;
    cycle();
    v[0] = 1; a[0] = 9; d[0] = 32'h99;
    cycle();
    v[0] = 0; rsv = 0;
    cycle();
    check("sim_busy", last_busy_a, 1'b1);
    check("sim_conflict", last_conf, 1'b0);
    rsv = 1;
    cycle();
    rsv = 0;
    cycle();
    check("sim_conflict2", last_conf, 1'b1);
    cycle();
    check("sim_conflict_end", last_conf, 1'b0);

    // Randomized traffic with a reset dropped in mid-stream
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < NR; k++) begin
        if (!(v[k] && last_g != k && $urandom_range(0, 3) != 0)) begin
          v[k] = 1'($urandom_range(0, 1));
          a[k] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 11));
          d[k] = $urandom;
        end
      end
      rsv   = ($urandom_range(0, 2) == 0);
      rsv_a = $urandom_range(0, 11);
      ca    = $urandom_range(0, 11);
      cb    = $urandom_range(0, 11);
      if (i == 200) begin
        v[0] = 1'b1;
        apply();
        #2;
        rst_ni = 1'b0;
        #1;
        check("mid_rst_ready", bus.req_ready_o, '0);
        check("mid_rst_we", bus.we_o, 1'b0);
        check("mid_rst_waddr", bus.waddr_o, '0);
        check("mid_rst_wdata", bus.wdata_o, '0);
        check("mid_rst_conflict", bus.rsv_conflict_o, 1'b0);
        check("mid_rst_busy_a", bus.busy_a_o, 1'b0);
        check("mid_rst_busy_b", bus.busy_b_o, 1'b0);
        model_reset();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        v[0] = 1'b1; v[1] = 1'b1;
        cycle();
        check("rst_first_grant", last_ready, 2'b01);
      end else begin
        cycle();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
